// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq_if
//  Description : Handshake/operand/result bundle between the control unit
//                and the multi-cycle multiply/divide sequencer.
//                master = control unit, slave = alu_muldiv_seq.
//  Signals     : start  - request a new operation (sampled when busy=0)
//                op     - 0 = signed multiply, 1 = signed divide
//                a, b   - multiplicand/dividend, multiplier/divisor
//                busy   - operation in progress
//                done   - one-cycle pulse, z_hi/z_lo valid
//                z_hi   - MUL: P[63:32]; DIV: remainder
//                z_lo   - MUL: P[31:0];  DIV: quotient
//                div_zero - only when MULDIV_DIVZERO_FLAG_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_muldiv_seq_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic        div_zero;

    modport master (output start, op, a, b,
                    input  busy, done, z_hi, z_lo, div_zero);
    modport slave  (input  start, op, a, b,
                    output busy, done, z_hi, z_lo, div_zero);
`else
    modport master (output start, op, a, b,
                    input  busy, done, z_hi, z_lo);
    modport slave  (input  start, op, a, b,
                    output busy, done, z_hi, z_lo);
`endif
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq
//  Description : Multi-cycle signed multiply/divide sequencer. Latches the
//                operands on a start handshake, captures the product of a
//                combinational radix-4 Booth multiplier after MUL_LATENCY
//                cycles, or runs a 32-iteration signed restoring division.
//                Results appear on a registered HI/LO pair with a one-cycle
//                done pulse.
//  Parameters  : MUL_LATENCY - cycles from operand latch to product capture
//                              (legal 1..4)
//  Ports       : clock - system clock, rising edge
//                clear - asynchronous active-high reset
//                bus   - alu_muldiv_seq_if.slave (start/op/a/b in,
//                        busy/done/z_hi/z_lo[/div_zero] out)
//  Options     : MULDIV_DIVZERO_FLAG_EN - adds div_zero output and a fast
//                divide-by-zero path (result ready 3 cycles after start).
//  Revision    : 1.0 - initial release
// ============================================================================

// Combinational 32x32 signed radix-4 Booth multiplier.
module booth_mul32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_p
);
    logic [63:0] w_a_ext;
    logic [32:0] w_b_ext;
    logic [63:0] w_pp;
    logic [63:0] w_acc;

    assign w_a_ext = {{32{i_a[31]}}, i_a};
    // Implicit zero below the LSB starts the first Booth triplet.
    assign w_b_ext = {i_b, 1'b0};

    always_comb begin
        w_acc = '0;
        w_pp  = '0;
        for (int i = 0; i < 16; i++) begin
            case (w_b_ext[2*i +: 3])
                3'b001, 3'b010: w_pp = w_a_ext;
                3'b011:         w_pp = w_a_ext << 1;
                3'b100:         w_pp = 64'd0 - (w_a_ext << 1);
                3'b101, 3'b110: w_pp = 64'd0 - w_a_ext;
                default:        w_pp = '0;
            endcase
            w_acc = w_acc + (w_pp << (2 * i));
        end
    end

    assign o_p = w_acc;
endmodule

module alu_muldiv_seq #(
    parameter int MUL_LATENCY = 1
) (
    input  logic            clock,
    input  logic            clear,
    alu_muldiv_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_WAIT = 3'd1,
        S_DIV_PREP = 3'd2,
        S_DIV_ITER = 3'd3,
        S_DIV_FIX  = 3'd4
    } state_t;

    localparam logic [4:0] c_mul_last = 5'(MUL_LATENCY - 1);
    localparam logic [4:0] c_div_last = 5'd31;

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_cnt;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [32:0] r_dvs;
    logic        r_q_sign;
    logic        r_r_sign;
    logic        r_dvz;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_z_hi;
    logic [31:0] r_z_lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic        r_div_zero;
`endif

    logic [63:0] w_prod;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [33:0] w_shift;
    logic [33:0] w_trial;
    logic        w_trial_neg;

    booth_mul32 u_booth (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude 2^31.
    assign w_a_mag = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_b_mag = r_b[31] ? (32'd0 - r_b) : r_b;

    // {rem, quo} shifted left by one, then trial subtraction of the divisor.
    // Both operands are below 2^33, so bit 33 is a reliable borrow flag.
    assign w_shift     = {r_rem, r_quo[31]};
    assign w_trial     = w_shift - {1'b0, r_dvs};
    assign w_trial_neg = w_trial[33];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_q_sign   <= 1'b0;
            r_r_sign   <= 1'b0;
            r_dvz      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_z_hi     <= '0;
            r_z_lo     <= '0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            r_div_zero <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= bus.op ? S_DIV_PREP : S_MUL_WAIT;
                    end
                end

                S_MUL_WAIT: begin
                    if (r_cnt == c_mul_last) begin
                        r_cnt      <= '0;
                        r_z_hi     <= w_prod[63:32];
                        r_z_lo     <= w_prod[31:0];
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
                        r_div_zero <= 1'b0;
`endif
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                S_DIV_PREP: begin
                    r_rem    <= '0;
                    r_quo    <= w_a_mag;
                    r_dvs    <= {1'b0, w_b_mag};
                    r_q_sign <= r_a[31] ^ r_b[31];
                    r_r_sign <= r_a[31];
                    r_dvz    <= (r_b == 32'd0);
                    r_cnt    <= '0;
`ifdef MULDIV_DIVZERO_FLAG_EN
                    r_state  <= (r_b == 32'd0) ? S_DIV_FIX : S_DIV_ITER;
`else
                    r_state  <= S_DIV_ITER;
`endif
                end

                S_DIV_ITER: begin
                    r_quo <= {r_quo[30:0], ~w_trial_neg};
                    r_rem <= w_trial_neg ? w_shift[32:0] : w_trial[32:0];
                    if (r_cnt == c_div_last) begin
                        r_cnt   <= '0;
                        r_state <= S_DIV_FIX;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                S_DIV_FIX: begin
                    if (r_dvz) begin
                        r_z_lo <= 32'hFFFF_FFFF;
                        r_z_hi <= r_a;
                    end else begin
                        r_z_lo <= r_q_sign ? (32'd0 - r_quo) : r_quo;
                        r_z_hi <= r_r_sign ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
                    end
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
                    r_div_zero <= r_dvz;
`endif
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.z_hi     = r_z_hi;
    assign bus.z_lo     = r_z_lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
    assign bus.div_zero = r_div_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv_seq
//  Description : Directed self-checking bench for alu_muldiv_seq. Two DUT
//                instances: MUL_LATENCY=1 (main) and MUL_LATENCY=3.
//                Honours MULDIV_DIVZERO_FLAG_EN for the divide-by-zero case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;
    logic clock = 1'b0;
    logic clear;

    always #5 clock = ~clock;

    alu_muldiv_seq_if bus  ();
    alu_muldiv_seq_if bus3 ();

    alu_muldiv_seq #(.MUL_LATENCY(1)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    alu_muldiv_seq #(.MUL_LATENCY(3)) dut3 (
        .clock (clock),
        .clear (clear),
        .bus   (bus3)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus driver: issues one op on the selected DUT and waits (bounded)
    // for done. lat is the cycle index of done, counting the cycle right
    // after the accepting edge as 1; -1 on timeout.
    task automatic run_op(input bit sel, input logic op, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int busy_cyc,
                          output logic busy_at_done, output logic [31:0] hi,
                          output logic [31:0] lo);
        logic d;
        logic bz;
        @(negedge clock);
        if (sel) begin
            bus3.start = 1'b1; bus3.op = op; bus3.a = a; bus3.b = b;
        end else begin
            bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        end
        @(posedge clock); #1;
        bus.start  = 1'b0;
        bus3.start = 1'b0;
        lat = -1; busy_cyc = 0; busy_at_done = 1'bx; hi = 'x; lo = 'x;
        for (int c = 1; c <= 60; c++) begin
            d  = sel ? bus3.done : bus.done;
            bz = sel ? bus3.busy : bus.busy;
            if (d === 1'b1) begin
                lat = c;
                busy_at_done = bz;
                hi = sel ? bus3.z_hi : bus.z_hi;
                lo = sel ? bus3.z_lo : bus.z_lo;
                break;
            end
            if (bz === 1'b1) busy_cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        bus.start = 1'b0;  bus.op = 1'b0;  bus.a = '0;  bus.b = '0;
        bus3.start = 1'b0; bus3.op = 1'b0; bus3.a = '0; bus3.b = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        @(posedge clock); #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        vectors++;
        if (bus.z_hi !== 32'd0 || bus.z_lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_z: z_hi=%h z_lo=%h expected 0 0", bus.z_hi, bus.z_lo);
        end
`ifdef MULDIV_DIVZERO_FLAG_EN
        vectors++;
        if (bus.div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_div_zero: got %b expected 0", bus.div_zero);
        end
`endif
    endtask

    task automatic test_multiply();
        int lat; int bc; logic bd; logic [31:0] hi; logic [31:0] lo;
        // 7 * -3 = -21
        run_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, lat, bc, bd, hi, lo);
        vectors++;
        if (lat != 2 || bc != 1 || bd !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_7x-3_timing: lat=%0d busy_cycles=%0d busy_at_done=%b expected 2 1 0", lat, bc, bd);
        end
        vectors++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            miscompares++;
            $display("FAIL mul_7x-3: got %h_%h expected ffffffff_ffffffeb", hi, lo);
        end
        // done is a single-cycle pulse and the result holds afterwards
        @(posedge clock); #1;
        vectors++;
        if (bus.done !== 1'b0 || bus.z_lo !== 32'hFFFF_FFEB) begin
            miscompares++;
            $display("FAIL mul_done_pulse: done=%b z_lo=%h expected 0 ffffffeb", bus.done, bus.z_lo);
        end
        // most-negative squared = 2^62
        run_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, lat, bc, bd, hi, lo);
        vectors++;
        if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL mul_min_sq: got %h_%h expected 40000000_00000000", hi, lo);
        end
        // (2^31-1)^2 = 0x3FFFFFFF_00000001
        run_op(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, bc, bd, hi, lo);
        vectors++;
        if (hi !== 32'h3FFF_FFFF || lo !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL mul_max_sq: got %h_%h expected 3fffffff_00000001", hi, lo);
        end
        // -5 * -6 = 30
        run_op(1'b0, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, lat, bc, bd, hi, lo);
        vectors++;
        if (hi !== 32'h0000_0000 || lo !== 32'd30) begin
            miscompares++;
            $display("FAIL mul_neg_neg: got %h_%h expected 00000000_0000001e", hi, lo);
        end
        // MUL_LATENCY=3 instance: done at N+4
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, lat, bc, bd, hi, lo);
        vectors++;
        if (lat != 4 || bc != 3) begin
            miscompares++;
            $display("FAIL mul_lat3_timing: lat=%0d busy_cycles=%0d expected 4 3", lat, bc);
        end
        vectors++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            miscompares++;
            $display("FAIL mul_lat3: got %h_%h expected ffffffff_ffffffeb", hi, lo);
        end
    endtask

    task automatic test_divide();
        int lat; int bc; logic bd; logic [31:0] hi; logic [31:0] lo;
        // -7 / 2 = -3 rem -1
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc, bd, hi, lo);
        vectors++;
        if (lat != 35 || bc != 34 || bd !== 1'b0) begin
            miscompares++;
            $display("FAIL div_timing: lat=%0d busy_cycles=%0d busy_at_done=%b expected 35 34 0", lat, bc, bd);
        end
        vectors++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL div_-7/2: got q=%h r=%h expected fffffffd ffffffff", lo, hi);
        end
        // 100 / 7 = 14 rem 2
        run_op(1'b0, 1'b1, 32'd100, 32'd7, lat, bc, bd, hi, lo);
        vectors++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            miscompares++;
            $display("FAIL div_100/7: got q=%h r=%h expected 0000000e 00000002", lo, hi);
        end
        // overflow: 0x80000000 / -1
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, bd, hi, lo);
        vectors++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL div_overflow: got q=%h r=%h expected 80000000 00000000", lo, hi);
        end
        // 5 / -10 = 0 rem 5
        run_op(1'b0, 1'b1, 32'd5, 32'hFFFF_FFF6, lat, bc, bd, hi, lo);
        vectors++;
        if (lo !== 32'd0 || hi !== 32'd5) begin
            miscompares++;
            $display("FAIL div_5/-10: got q=%h r=%h expected 00000000 00000005", lo, hi);
        end
    endtask

    task automatic test_ignore_and_abort();
        int lat; int bc; logic bd; logic [31:0] hi; logic [31:0] lo;
        bit seen;
        // divide 1000 / -3 with a stray multiply start mid-operation
        @(negedge clock);
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd1000; bus.b = 32'hFFFF_FFFD;
        @(posedge clock); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (c == 4) begin
                bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd3; bus.b = 32'd4;
            end
            if (c == 5) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = c; hi = bus.z_hi; lo = bus.z_lo;
                break;
            end
            @(posedge clock); #1;
        end
        vectors++;
        if (lat != 35 || lo !== 32'hFFFF_FEB3 || hi !== 32'd1) begin
            miscompares++;
            $display("FAIL div_ignore_start: lat=%0d q=%h r=%h expected 35 fffffeb3 00000001", lat, lo, hi);
        end
        // abort a divide with clear at cycle 10
        @(negedge clock);
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd1000; bus.b = 32'hFFFF_FFFD;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        clear = 1'b1;
        #2;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.z_hi !== 32'd0 || bus.z_lo !== 32'd0) begin
            miscompares++;
            $display("FAIL abort_clear: busy=%b done=%b z=%h_%h expected 0 0 0_0", bus.busy, bus.done, bus.z_hi, bus.z_lo);
        end
        @(negedge clock);
        clear = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: done seen=%b expected 0", seen);
        end
        run_op(1'b0, 1'b0, 32'd3, 32'd4, lat, bc, bd, hi, lo);
        vectors++;
        if (lat != 2 || lo !== 32'd12 || hi !== 32'd0) begin
            miscompares++;
            $display("FAIL mul_after_abort: lat=%0d got %h_%h expected 2 00000000_0000000c", lat, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clock);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd2; bus.b = 32'd3;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.z_lo !== 32'd6) begin
            miscompares++;
            $display("FAIL b2b_first: done=%b busy=%b z_lo=%h expected 1 0 00000006", bus.done, bus.busy, bus.z_lo);
        end
        // issue the next op in the done cycle
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clock); #1;
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.z_lo !== 32'd6 || bus.z_hi !== 32'd0) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b done=%b z=%h_%h expected 1 0 00000000_00000006", bus.busy, bus.done, bus.z_hi, bus.z_lo);
        end
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clock); #1;
        end
        vectors++;
        if (lat != 35 || bus.z_lo !== 32'd14 || bus.z_hi !== 32'd2) begin
            miscompares++;
            $display("FAIL b2b_second: lat=%0d q=%h r=%h expected 35 0000000e 00000002", lat, bus.z_lo, bus.z_hi);
        end
    endtask

    task automatic test_div_zero();
        int lat; int bc; logic bd; logic [31:0] hi; logic [31:0] lo;
        int exp_lat;
`ifdef MULDIV_DIVZERO_FLAG_EN
        exp_lat = 3;
`else
        exp_lat = 35;
`endif
        run_op(1'b0, 1'b1, 32'h0000_1234, 32'd0, lat, bc, bd, hi, lo);
        vectors++;
        if (lat != exp_lat) begin
            miscompares++;
            $display("FAIL divzero_timing: lat=%0d expected %0d", lat, exp_lat);
        end
        vectors++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL divzero_result: q=%h r=%h expected ffffffff 00001234", lo, hi);
        end
`ifdef MULDIV_DIVZERO_FLAG_EN
        vectors++;
        if (bus.div_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL divzero_flag: got %b expected 1", bus.div_zero);
        end
`endif
        run_op(1'b0, 1'b1, 32'd8, 32'd2, lat, bc, bd, hi, lo);
        vectors++;
        if (lo !== 32'd4 || hi !== 32'd0) begin
            miscompares++;
            $display("FAIL div_8/2: q=%h r=%h expected 00000004 00000000", lo, hi);
        end
`ifdef MULDIV_DIVZERO_FLAG_EN
        vectors++;
        if (bus.div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL divzero_flag_clear: got %b expected 0", bus.div_zero);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_ignore_and_abort();
        test_back_to_back();
        test_div_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
